// File: rtl/conc_reduce_if.sv
// Result-set input stream and reduced-result output stream of conc_reduce.
interface conc_reduce_if #(parameter int W = 32);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b, c, d, e;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic [W-1:0] out_xor;
   logic [7:0]   out_tag;

   modport master (
      output in_valid, a, b, c, d, e, out_ready,
      input  in_ready, out_valid, out_sum, out_xor, out_tag
   );

   modport slave (
      input  in_valid, a, b, c, d, e, out_ready,
      output in_ready, out_valid, out_sum, out_xor, out_tag
   );
endinterface

// File: rtl/conc_reduce.sv
// Buffers {a,b,c,d,e} result sets in a FIFO and reduces each one serially
// to a W-bit sum and XOR digest, presented with a rolling 8-bit tag.
//
// state | meaning
// IDLE  | working registers empty, waiting for a FIFO entry
// ACC   | folding elem[idx] into acc_sum/acc_xor, one element per cycle
// HOLD  | result presented on out_*, waiting for out_ready
module conc_reduce #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   conc_reduce_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t         state, state_n;
   logic [5*W-1:0] mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [PW:0]    count;
   logic [W-1:0]   work [5];
   logic [2:0]     idx;
   logic [W-1:0]   acc_sum, acc_xor, sum_n, xor_n;
   logic [W-1:0]   out_sum_q, out_xor_q;
   logic [7:0]     tag_q;
   logic           push, pop, fire;

   // in_ready looks only at the registered count, never at out_ready.
   assign bus.in_ready = rst_n && (count != FULL);
   assign push         = bus.in_valid && bus.in_ready;
   assign fire         = (state == HOLD) && bus.out_ready;
   assign sum_n        = acc_sum + work[idx];
   assign xor_n        = acc_xor ^ work[idx];

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_n = ACC;
            end
         end
         ACC: begin
            if (idx == 3'd4) state_n = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               if (count != '0) begin
                  pop     = 1'b1;
                  state_n = ACC;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.e, bus.d, bus.c, bus.b, bus.a};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_n;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) work[i] <= '0;
         idx       <= '0;
         acc_sum   <= '0;
         acc_xor   <= '0;
         out_sum_q <= '0;
         out_xor_q <= '0;
         tag_q     <= '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < 5; i++) work[i] <= mem[rd_ptr][i*W +: W];
            idx     <= '0;
            acc_sum <= '0;
            acc_xor <= '0;
         end else if (state == ACC) begin
            acc_sum <= sum_n;
            acc_xor <= xor_n;
            idx     <= idx + 3'd1;
            if (idx == 3'd4) begin
               out_sum_q <= sum_n;
               out_xor_q <= xor_n;
            end
         end
         if (fire) tag_q <= tag_q + 8'd1;
      end
   end

   assign bus.out_valid = (state == HOLD);
   assign bus.out_sum   = out_sum_q;
   assign bus.out_xor   = out_xor_q;
   assign bus.out_tag   = tag_q;
endmodule
